sseg_scan_driver: RTL and testbench

//  Downstream display stage for the digital clock core. Latches four BCD digits (HH:MM, or a

---
 rtl/sseg_scan_driver.sv | 212 +++++++++++++++++++++
 tb/tb_sseg_scan_driver.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_driver.sv
// rtl/sseg_scan_driver.sv - 4-digit common-anode 7-segment scan driver with digit/colon blink
// Optional feature macro: SSEG_LZ_SUPPRESS_EN (darkens the leftmost digit when it is zero)
module sseg_scan_driver #(
    parameter int REFRESH_TICKS = 49999,
    parameter int HALFSEC       = 24999999
) (
    input  logic        M_CLOCK,
    input  logic        M_RESET_N,
    input  logic [15:0] DIGITS,
    input  logic        LOAD,
    input  logic [3:0]  BLINK_MASK,
    input  logic [3:0]  DP_MASK,
    input  logic        COL_EN,
    input  logic        COL_BLINK,
    input  logic        BLANK,
    output logic        LOAD_ACK,
    output logic [7:0]  IO_SSEG,
    output logic [3:0]  IO_SSEGD,
    output logic        IO_SSEG_COL
);

    localparam int RW = (REFRESH_TICKS > 0) ? $clog2(REFRESH_TICKS + 1) : 1;
    localparam int BW = (HALFSEC > 0) ? $clog2(HALFSEC + 1) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_TICKS);
    localparam logic [BW-1:0] HALFSEC_LAST = BW'(HALFSEC);

    // Timebase state
    logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [1:0]    scan_idx_q, scan_idx_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic          slot_end;

    // Shadow registers written by LOAD
    logic [15:0] sh_digits_q, sh_digits_d;
    logic [3:0]  sh_blink_q, sh_blink_d;
    logic [3:0]  sh_dp_q, sh_dp_d;
    logic        sh_col_en_q, sh_col_en_d;

    // Per-slot copy of the shadow, refreshed only at slot boundaries so a
    // LOAD can never change a digit half way through its slot
    logic [15:0] act_digits_q, act_digits_d;
    logic [3:0]  act_blink_q, act_blink_d;
    logic [3:0]  act_dp_q, act_dp_d;

    // Registered outputs
    logic [7:0] sseg_q, sseg_d;
    logic [3:0] ssegd_q, ssegd_d;
    logic       col_q, col_d;
    logic       ack_q, ack_d;

    // Slot datapath intermediates
    logic [3:0] slot_bcd;
    logic       slot_blink;
    logic       slot_dp;
    logic [3:0] slot_en;
    logic [7:0] slot_seg;
    logic       slot_dark;
    logic       lz_dark;

    // BCD to active-low segments {dp,g,f,e,d,c,b,a}; non-decimal codes show a dash
    function automatic logic [7:0] seg_decode(input logic [3:0] bcd);
        logic [7:0] seg;
        case (bcd)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h98;
            default: seg = 8'hBF;
        endcase
        return seg;
    endfunction

    // Refresh counter, scan index and free-running blink phase
    always_comb begin
        refresh_cnt_d = refresh_cnt_q + RW'(1);
        scan_idx_d    = scan_idx_q;
        blink_cnt_d   = blink_cnt_q + BW'(1);
        phase_d       = phase_q;
        slot_end      = (refresh_cnt_q == REFRESH_LAST);
        if (slot_end) begin
            refresh_cnt_d = '0;
            scan_idx_d    = scan_idx_q + 2'd1;
        end
        if (blink_cnt_q == HALFSEC_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    // Shadow capture on LOAD and slot-boundary transfer into the active copy
    always_comb begin
        sh_digits_d  = sh_digits_q;
        sh_blink_d   = sh_blink_q;
        sh_dp_d      = sh_dp_q;
        sh_col_en_d  = sh_col_en_q;
        act_digits_d = act_digits_q;
        act_blink_d  = act_blink_q;
        act_dp_d     = act_dp_q;
        if (LOAD) begin
            sh_digits_d = DIGITS;
            sh_blink_d  = BLINK_MASK;
            sh_dp_d     = DP_MASK;
            sh_col_en_d = COL_EN;
        end
        if (slot_end) begin
            act_digits_d = sh_digits_q;
            act_blink_d  = sh_blink_q;
            act_dp_d     = sh_dp_q;
        end
    end

    // Select the digit, mask bits and anode enable for the current slot
    always_comb begin
        slot_bcd   = act_digits_q[15:12];
        slot_blink = act_blink_q[3];
        slot_dp    = act_dp_q[3];
        slot_en    = 4'b0111;
        case (scan_idx_q)
            2'd0: begin
                slot_bcd   = act_digits_q[15:12];
                slot_blink = act_blink_q[3];
                slot_dp    = act_dp_q[3];
                slot_en    = 4'b0111;
            end
            2'd1: begin
                slot_bcd   = act_digits_q[11:8];
                slot_blink = act_blink_q[2];
                slot_dp    = act_dp_q[2];
                slot_en    = 4'b1011;
            end
            2'd2: begin
                slot_bcd   = act_digits_q[7:4];
                slot_blink = act_blink_q[1];
                slot_dp    = act_dp_q[1];
                slot_en    = 4'b1101;
            end
            default: begin
                slot_bcd   = act_digits_q[3:0];
                slot_blink = act_blink_q[0];
                slot_dp    = act_dp_q[0];
                slot_en    = 4'b1110;
            end
        endcase
    end

`ifdef SSEG_LZ_SUPPRESS_EN
    assign lz_dark = (scan_idx_q == 2'd0) && (act_digits_q[15:12] == 4'd0);
`else
    assign lz_dark = 1'b0;
`endif

    // Next output values: decoded segments gated by blank, blink and leading-zero darkening
    always_comb begin
        slot_seg  = seg_decode(slot_bcd);
        slot_seg[7] = ~slot_dp;
        slot_dark = BLANK | lz_dark | (slot_blink & ~phase_q);
        sseg_d    = slot_dark ? 8'hFF : slot_seg;
        ssegd_d   = slot_dark ? 4'hF : slot_en;
        col_d     = ~(sh_col_en_q & ~BLANK & (~COL_BLINK | phase_q));
        ack_d     = LOAD;
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge M_CLOCK) begin
        if (!M_RESET_N) begin
            refresh_cnt_q <= '0;
            scan_idx_q    <= 2'd0;
            blink_cnt_q   <= '0;
            phase_q       <= 1'b1;
            sh_digits_q   <= 16'h0000;
            sh_blink_q    <= 4'h0;
            sh_dp_q       <= 4'h0;
            sh_col_en_q   <= 1'b0;
            act_digits_q  <= 16'h0000;
            act_blink_q   <= 4'h0;
            act_dp_q      <= 4'h0;
            sseg_q        <= 8'hFF;
            ssegd_q       <= 4'hF;
            col_q         <= 1'b1;
            ack_q         <= 1'b0;
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
            scan_idx_q    <= scan_idx_d;
            blink_cnt_q   <= blink_cnt_d;
            phase_q       <= phase_d;
            sh_digits_q   <= sh_digits_d;
            sh_blink_q    <= sh_blink_d;
            sh_dp_q       <= sh_dp_d;
            sh_col_en_q   <= sh_col_en_d;
            act_digits_q  <= act_digits_d;
            act_blink_q   <= act_blink_d;
            act_dp_q      <= act_dp_d;
            sseg_q        <= sseg_d;
            ssegd_q       <= ssegd_d;
            col_q         <= col_d;
            ack_q         <= ack_d;
        end
    end

    assign IO_SSEG     = sseg_q;
    assign IO_SSEGD    = ssegd_q;
    assign IO_SSEG_COL = col_q;
    assign LOAD_ACK    = ack_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb/tb_sseg_scan_driver.sv - self-checking bench for sseg_scan_driver
module tb_sseg_scan_driver;

    localparam int R = 3;
    localparam int H = 9;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits;
    logic        load;
    logic [3:0]  blink_mask;
    logic [3:0]  dp_mask;
    logic        col_en;
    logic        col_blink;
    logic        blank;
    logic        load_ack;
    logic [7:0]  io_sseg;
    logic [3:0]  io_ssegd;
    logic        io_sseg_col;

    always #5 clk = ~clk;

    sseg_scan_driver #(.REFRESH_TICKS(R), .HALFSEC(H)) dut (
        .M_CLOCK     (clk),
        .M_RESET_N   (rst_n),
        .DIGITS      (digits),
        .LOAD        (load),
        .BLINK_MASK  (blink_mask),
        .DP_MASK     (dp_mask),
        .COL_EN      (col_en),
        .COL_BLINK   (col_blink),
        .BLANK       (blank),
        .LOAD_ACK    (load_ack),
        .IO_SSEG     (io_sseg),
        .IO_SSEGD    (io_ssegd),
        .IO_SSEG_COL (io_sseg_col)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Reference model: time since reset drives slot index and blink phase arithmetically
    int unsigned k;
    logic [15:0] sh_dig, act_dig;
    logic [3:0]  sh_blink, act_blink, sh_dp, act_dp;
    logic        sh_col;
    logic [7:0]  m_seg;
    logic [3:0]  m_segd;
    logic        m_col, m_ack;
    int          m_idx;
    logic [7:0]  seg_tbl [16];

    initial begin
        seg_tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h98, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};
    end

    always @(posedge clk) begin
        int          idx;
        bit          ph;
        bit          dark;
        logic [3:0]  d;
        logic [3:0]  onehot;
        if (!rst_n) begin
            k = 0;
            sh_dig = '0; act_dig = '0; sh_blink = '0; act_blink = '0;
            sh_dp = '0; act_dp = '0; sh_col = 1'b0;
            m_seg = 8'hFF; m_segd = 4'hF; m_col = 1'b1; m_ack = 1'b0; m_idx = 0;
        end else begin
            idx  = (k / (R + 1)) % 4;
            ph   = ((k / (H + 1)) % 2) == 0;
            d    = act_dig[4*(3-idx) +: 4];
            dark = blank || (act_blink[3-idx] && !ph);
`ifdef SSEG_LZ_SUPPRESS_EN
            if (idx == 0 && d == 4'd0) dark = 1'b1;
`endif
            onehot = 4'b1000;
            m_segd = dark ? 4'hF : ~(onehot >> idx);
            m_seg  = dark ? 8'hFF : (seg_tbl[d] & (act_dp[3-idx] ? 8'h7F : 8'hFF));
            m_col  = !(sh_col && !blank && (!col_blink || ph));
            m_ack  = load;
            m_idx  = idx;
            if (k % (R + 1) == R) begin
                act_dig = sh_dig; act_blink = sh_blink; act_dp = sh_dp;
            end
            if (load) begin
                sh_dig = digits; sh_blink = blink_mask; sh_dp = dp_mask; sh_col = col_en;
            end
            k++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (chk_en) begin
            check("model_sseg", 32'(io_sseg), 32'(m_seg));
            check("model_ssegd", 32'(io_ssegd), 32'(m_segd));
            check("model_col", 32'(io_sseg_col), 32'(m_col));
            check("model_ack", 32'(load_ack), 32'(m_ack));
        end
    endtask

    typedef struct packed {
        logic [15:0] dig;
        logic [3:0]  dp;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [5];
    logic [31:0] e;
    logic [7:0]  exp_seg;
    int          col_dark;

    initial begin
        vecs[0] = '{16'h1234, 4'b0000, 32'hF9A4B099};
        vecs[1] = '{16'h12A5, 4'b0100, 32'hF924BF92};
        vecs[2] = '{16'h0945, 4'b0000, 32'hC0989992};
        vecs[3] = '{16'h8F6B, 4'b1111, 32'h003F023F};
        vecs[4] = '{16'h7C09, 4'b1001, 32'h78BFC018};

        rst_n = 1'b0; digits = '0; load = 1'b0; blink_mask = '0; dp_mask = '0;
        col_en = 1'b0; col_blink = 1'b0; blank = 1'b0;

        // Reset held two cycles
        step();
        chk_en = 1'b1;
        step();
        check("rst_sseg", 32'(io_sseg), 32'h0000_00FF);
        check("rst_ssegd", 32'(io_ssegd), 32'h0000_000F);
        check("rst_col", 32'(io_sseg_col), 32'h1);
        check("rst_ack", 32'(load_ack), 32'h0);

        // First slot after release is idx0 showing the zero shadow
        rst_n = 1'b1;
        step();
`ifdef SSEG_LZ_SUPPRESS_EN
        check("first_ssegd", 32'(io_ssegd), 32'hF);
        check("first_sseg", 32'(io_sseg), 32'hFF);
`else
        check("first_ssegd", 32'(io_ssegd), 32'b0111);
        check("first_sseg", 32'(io_sseg), 32'hC0);
`endif

        // LOAD_ACK: single pulse, then held LOAD keeps it high
        digits = 16'h1234; load = 1'b1;
        step();
        check("ack_pulse", 32'(load_ack), 32'h1);
        step();
        check("ack_held", 32'(load_ack), 32'h1);
        load = 1'b0;
        step();
        check("ack_drop", 32'(load_ack), 32'h0);

        // Table vectors: static digit/dp patterns checked slot by slot
        for (int i = 0; i < 5; i++) begin
            digits = vecs[i].dig; dp_mask = vecs[i].dp; blink_mask = '0; col_en = 1'b0;
            load = 1'b1;
            step();
            load = 1'b0;
            e = vecs[i].exp;
            for (int c = 0; c < 24; c++) begin
                step();
                if (c >= 8) begin
                    exp_seg = e[31-8*m_idx -: 8];
`ifdef SSEG_LZ_SUPPRESS_EN
                    if (m_idx == 0 && vecs[i].dig[15:12] == 4'd0) exp_seg = 8'hFF;
`endif
                    check("table_seg", 32'(io_sseg), 32'(exp_seg));
                end
            end
        end

        // Blink on leftmost digit and colon
        digits = 16'h1234; dp_mask = '0; blink_mask = 4'b1000;
        col_en = 1'b1; col_blink = 1'b1; load = 1'b1;
        step();
        load = 1'b0;
        for (int c = 0; c < 8; c++) step();
        col_dark = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (io_sseg_col) col_dark++;
        end
        check("colon_dark_count", 32'(col_dark), 32'd20);

        // BLANK mid-slot, then resume
        col_blink = 1'b0;
        for (int c = 0; c < 2; c++) step();
        blank = 1'b1;
        step();
        check("blank_ssegd", 32'(io_ssegd), 32'hF);
        check("blank_sseg", 32'(io_sseg), 32'hFF);
        check("blank_col", 32'(io_sseg_col), 32'h1);
        for (int c = 0; c < 5; c++) step();
        blank = 1'b0;
        for (int c = 0; c < 16; c++) step();

        // Randomized stimulus against the model
        for (int c = 0; c < 600; c++) begin
            rst_n      = ($urandom_range(0, 149) != 0);
            load       = ($urandom_range(0, 7) == 0);
            digits     = 16'($urandom);
            blink_mask = 4'($urandom);
            dp_mask    = 4'($urandom);
            col_en     = 1'($urandom);
            col_blink  = 1'($urandom);
            blank      = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
